// File: rtl/reg_skid_buf_rst_y_mode_s.sv
// Two-entry valid/ready skid buffer feeding a downstream enable register.
// Every output except o_fire comes straight from a flop, so o_in_ready never depends on i_out_ready.
//
//  state | meaning
//  EMPTY | no word held, head register shows the last popped word
//  BUSY  | one word held in the head register
//  FULL  | head register plus skid register occupied, producer stalled
module reg_skid_buf_rst_y_mode_s #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    input  logic                  i_out_ready,
    output logic                  o_fire,
    output logic [1:0]            o_level
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] skid;
    logic                  in_fire;
    logic                  main_load;
    logic                  main_from_skid;
    logic                  skid_load;
    logic [1:0]            level_nxt;

    assign o_fire  = o_out_valid & i_out_ready;
    assign in_fire = i_in_valid & o_in_ready;

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && o_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_nxt = ST_FULL;
                end else if (o_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (o_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ST_BUSY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        level_nxt = 2'd0;
        case (state_nxt)
            ST_BUSY: level_nxt = 2'd1;
            ST_FULL: level_nxt = 2'd2;
            default: level_nxt = 2'd0;
        endcase
    end

    // Status flops are loaded from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_EMPTY;
            o_in_ready  <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            skid        <= '0;
            o_level     <= 2'd0;
        end else begin
            state       <= state_nxt;
            o_in_ready  <= (state_nxt != ST_FULL);
            o_out_valid <= (state_nxt != ST_EMPTY);
            o_level     <= level_nxt;
            if (main_load) begin
                o_out_data <= main_from_skid ? skid : i_in_data;
            end
            if (skid_load) begin
                skid <= i_in_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_skid_buf_rst_y_mode_s.sv
// Bench for reg_skid_buf_rst_y_mode_s: directed scenarios followed by random traffic,
// all checked against a queue-based model of the buffer contents.
module tb_reg_skid_buf_rst_y_mode_s;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          fire;
    logic [1:0]    level;

    reg_skid_buf_rst_y_mode_s #(.DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .i_out_ready (out_ready),
        .o_fire      (fire),
        .o_level     (level)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;

    // Model: words currently held, in acceptance order, plus the registered ready flag.
    logic [DW-1:0] sb_q[$];
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_last  = '0;
    int            m_cnt;
    logic          e_fire;
    logic          e_in;
    logic [DW-1:0] e_head;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            m_cnt  = sb_q.size();
            e_head = (m_cnt > 0) ? sb_q[0] : m_last;
            e_fire = (m_cnt > 0) && out_ready;
            check("in_ready",  32'(in_ready),  32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(m_cnt > 0));
            check("level",     32'(level),     32'(m_cnt));
            check("fire",      32'(fire),      32'(e_fire));
            check("out_data",  out_data,       e_head);

            e_in = in_valid && m_ready;
            if (!rst_n) begin
                sb_q.delete();
                m_ready = 1'b0;
                m_last  = '0;
            end else begin
                if (e_fire) m_last = sb_q.pop_front();
                if (e_in) sb_q.push_back(in_data);
                m_ready = (sb_q.size() < 2);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a word and holds it until the buffer takes it; valid stays high on return.
    task automatic send(input logic [DW-1:0] w);
        logic ok;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 50; k++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: word %h not accepted after 50 cycles", w);
    endtask

    initial begin
        logic acc;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF0000;
        out_ready = 1'b0;
        cyc(2);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cyc(2);

        out_ready = 1'b1;
        send(32'hFFFF00FF);
        in_valid = 1'b0;
        cyc(3);

        out_ready = 1'b0;
        send(32'hA);
        send(32'hB);
        in_data = 32'hC;
        cyc(3);

        out_ready = 1'b1;
        send(32'hC);
        in_valid = 1'b0;
        cyc(4);

        for (int i = 0; i < 16; i++) send(DW'(i));
        in_valid = 1'b0;
        cyc(3);

        out_ready = 1'b0;
        send(32'h1);
        send(32'h2);
        in_valid = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        out_ready = 1'b1;
        cyc(4);

        acc      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 79) != 0);
            acc       = in_valid && in_ready && rst_n;
            cyc(1);
        end

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
